pe_out_drain: RTL and testbench

- Downstream stage of the 2x16 PE array.
- Captures one full snapshot of the array's 2x16 signed Q7.9 results when the controller strobes it.
- Holds snapshots in a ping-pong double buffer (two banks) and streams them out as LANES-wide beats over a valid/ready interface to the writeback/SRAM path.
- The array cannot stall, so a capture offered with no free bank is dropped and counted.

---
 rtl/pe_out_drain.sv | 157 +++++++++++++++
 tb/tb_pe_out_drain.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_out_drain.sv
// pe_out_drain: ping-pong snapshot buffer behind the 2x16 PE array.
// Captures ROWS*COLS elements and streams LANES-wide beats over valid/ready.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   cap_valid    snapshot strobe (array cannot stall)
//   cap_data     packed [ROWS][COLS][DW] snapshot
//   cap_ready    write-target bank is free
//   out_valid    beat valid
//   out_ready    downstream accept
//   out_data     LANES elements; lane l at [l*DW +: DW]
//   out_beat     beat index within snapshot
//   out_last     final beat of snapshot
//   overflow     sticky dropped-capture flag
//   drop_cnt     saturating dropped-capture count
//   clear_ovf    clears overflow and drop_cnt
//
// Optional: define PE_DRAIN_RELU_EN to zero negative elements at capture.

module pe_out_drain #(
    parameter  int ROWS  = 2,
    parameter  int COLS  = 16,
    parameter  int DW    = 16,
    parameter  int LANES = 4,
    localparam int NE    = ROWS * COLS,
    localparam int BEATS = NE / LANES,
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap_valid,
    input  logic [NE*DW-1:0]      cap_data,
    output logic                  cap_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_data,
    output logic [BW-1:0]         out_beat,
    output logic                  out_last,
    output logic                  overflow,
    output logic [7:0]            drop_cnt,
    input  logic                  clear_ovf
);

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } state_t;

    state_t            state;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_sel;
    logic              rd_sel;
    logic [BW-1:0]     beat_cnt;
    logic [NE*DW-1:0]  bank [2];
    logic [NE*DW-1:0]  cap_store;

    logic              cap_acc;
    logic              drop;
    logic              fire;
    logic              last_fire;
    logic              other_full;

    assign cap_ready = ~full[wr_sel];
    assign cap_acc   = !rst && cap_valid && cap_ready;
    assign drop      = !rst && cap_valid && !cap_ready;
    assign out_valid = (state == S_DRAIN);
    assign out_beat  = beat_cnt;
    assign out_last  = out_valid && (beat_cnt == BW'(BEATS - 1));
    assign fire      = out_valid && out_ready;
    assign last_fire = fire && (beat_cnt == BW'(BEATS - 1));

    // A capture landing in the other bank this cycle also counts as
    // full, so the next snapshot follows the last beat with no bubble.
    assign other_full = full[~rd_sel] |
                        (cap_acc && (wr_sel != rd_sel));

    always_comb begin
        cap_store = cap_data;
`ifdef PE_DRAIN_RELU_EN
        for (int i = 0; i < NE; i++) begin
            if (cap_data[i*DW + DW - 1])
                cap_store[i*DW +: DW] = '0;
        end
`endif
    end

    // A capture can never target the bank being freed: that bank is
    // still full at the edge, so cap_ready is 0 for it.
    always_comb begin
        full_nxt = full;
        if (last_fire)
            full_nxt[rd_sel] = 1'b0;
        if (cap_acc)
            full_nxt[wr_sel] = 1'b1;
    end

    always_comb begin
        out_data = '0;
        if (out_valid)
            out_data = bank[rd_sel][int'(beat_cnt)*LANES*DW +: LANES*DW];
    end

    always_ff @(posedge clk) begin
        if (cap_acc)
            bank[wr_sel] <= cap_store;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            full     <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            beat_cnt <= '0;
        end else begin
            full <= full_nxt;
            if (cap_acc)
                wr_sel <= ~wr_sel;
            unique case (state)
                S_IDLE: begin
                    // Bypass: a capture into the read bank starts the
                    // drain on the very next cycle.
                    if (full[rd_sel] ||
                        (cap_acc && (wr_sel == rd_sel)))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (last_fire) begin
                        rd_sel   <= ~rd_sel;
                        beat_cnt <= '0;
                        state    <= other_full ? S_DRAIN : S_IDLE;
                    end else if (fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Same-cycle clear and drop: the drop wins and counts as the first.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear_ovf) begin
            overflow <= drop;
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pe_out_drain.sv
// tb_pe_out_drain: directed self-checking bench for pe_out_drain.
// Linear stimulus; immediate assertions at every check point.

module tb_pe_out_drain;

    logic         clk = 1'b0;
    logic         rst;
    logic         cap_valid;
    logic [511:0] cap_data;
    logic         cap_ready;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [2:0]   out_beat;
    logic         out_last;
    logic         overflow;
    logic [7:0]   drop_cnt;
    logic         clear_ovf;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pe_out_drain dut (
        .clk       (clk),
        .rst       (rst),
        .cap_valid (cap_valid),
        .cap_data  (cap_data),
        .cap_ready (cap_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beat  (out_beat),
        .out_last  (out_last),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clear_ovf (clear_ovf)
    );

    function automatic logic [511:0] mk(input int base);
        logic [511:0] d;
        for (int i = 0; i < 32; i++)
            d[i*16 +: 16] = 16'(base + i);
        return d;
    endfunction

    function automatic logic [63:0] exp_beat(input int base, input int b);
        logic [63:0] r;
        for (int l = 0; l < 4; l++)
            r[l*16 +: 16] = 16'(base + b*4 + l);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int base, input int b);
        chk({tag, " valid"}, 64'(out_valid), 64'd1);
        chk({tag, " beat"}, 64'(out_beat), 64'(b));
        chk({tag, " data"}, out_data, exp_beat(base, b));
        chk({tag, " last"}, 64'(out_last), 64'(b == 7));
    endtask

    logic [511:0] rd;
    logic [63:0]  held;

    initial begin
        rst       = 1'b1;
        cap_valid = 1'b0;
        cap_data  = '0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst cap_ready", 64'(cap_ready), 64'd1);
        chk("rst out_last", 64'(out_last), 64'd0);
        chk("rst out_beat", 64'(out_beat), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        chk("rst overflow", 64'(overflow), 64'd0);
        chk("rst drop_cnt", 64'(drop_cnt), 64'd0);

        // single capture, element (m,n) = m*16+n
        out_ready = 1'b1;
        cap_valid = 1'b1;
        cap_data  = mk(0);
        tick();
        cap_valid = 1'b0;
        chk("t1 beat0 data", out_data, 64'h0003_0002_0001_0000);
        for (int b = 0; b < 8; b++) begin
            chk_beat("t1", 0, b);
            if (b == 4)
                chk("t1 beat4 data", out_data, 64'h0013_0012_0011_0010);
            tick();
        end
        chk("t1 done valid", 64'(out_valid), 64'd0);
        chk("t1 done data", out_data, 64'd0);

        // A, B, C back to back with downstream stalled
        out_ready = 1'b0;
        cap_valid = 1'b1;
        cap_data  = mk(16'h100);
        tick();
        cap_data  = mk(16'h200);
        tick();
        chk("t2 cap_ready full", 64'(cap_ready), 64'd0);
        cap_data  = mk(16'h300);
        tick();
        cap_valid = 1'b0;
        chk("t2 overflow", 64'(overflow), 64'd1);
        chk("t2 drop_cnt", 64'(drop_cnt), 64'd1);
        out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            chk_beat("t2 A", 16'h100, b);
            tick();
        end
        for (int b = 0; b < 8; b++) begin
            chk_beat("t2 B", 16'h200, b);
            tick();
        end
        chk("t2 done valid", 64'(out_valid), 64'd0);
        chk("t2 cap_ready", 64'(cap_ready), 64'd1);

        // clear alone
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("t3 clr overflow", 64'(overflow), 64'd0);
        chk("t3 clr drop_cnt", 64'(drop_cnt), 64'd0);

        // stall toggling mid-drain
        out_ready = 1'b0;
        cap_valid = 1'b1;
        cap_data  = mk(16'h400);
        tick();
        cap_valid = 1'b0;
        chk_beat("t3 start", 16'h400, 0);
        out_ready = 1'b1;
        tick();
        chk_beat("t3 hs1", 16'h400, 1);
        held = out_data;
        out_ready = 1'b0;
        tick();
        chk_beat("t3 st1", 16'h400, 1);
        chk("t3 st1 stable", out_data, held);
        out_ready = 1'b1;
        tick();
        chk_beat("t3 hs2", 16'h400, 2);
        held = out_data;
        out_ready = 1'b0;
        tick();
        chk_beat("t3 st2", 16'h400, 2);
        chk("t3 st2 stable", out_data, held);
        out_ready = 1'b1;
        for (int b = 2; b < 8; b++)
            tick();
        chk("t3 done valid", 64'(out_valid), 64'd0);

        // clear in the same cycle as a drop
        out_ready = 1'b0;
        cap_valid = 1'b1;
        cap_data  = mk(16'h500);
        tick();
        cap_data  = mk(16'h600);
        tick();
        cap_data  = mk(16'h0);
        clear_ovf = 1'b1;
        tick();
        chk("t4 set wins ovf", 64'(overflow), 64'd1);
        chk("t4 set wins cnt", 64'(drop_cnt), 64'd1);
        cap_valid = 1'b0;
        tick();
        clear_ovf = 1'b0;
        chk("t4 clr ovf", 64'(overflow), 64'd0);
        chk("t4 clr cnt", 64'(drop_cnt), 64'd0);
        cap_valid = 1'b1;
        for (int i = 0; i < 300; i++)
            tick();
        cap_valid = 1'b0;
        chk("t4 sat cnt", 64'(drop_cnt), 64'd255);
        chk("t4 sat ovf", 64'(overflow), 64'd1);

        // reset at beat 3 with both banks full
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk_beat("t5 pre", 16'h500, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5 rst valid", 64'(out_valid), 64'd0);
        chk("t5 rst cap_ready", 64'(cap_ready), 64'd1);
        chk("t5 rst drop_cnt", 64'(drop_cnt), 64'd0);
        cap_valid = 1'b1;
        cap_data  = mk(16'h700);
        tick();
        cap_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            chk_beat("t5 G", 16'h700, b);
            tick();
        end
        chk("t5 done valid", 64'(out_valid), 64'd0);

        // sign handling (ReLU when enabled)
        rd = '0;
        rd[15:0]  = 16'hFE00;
        rd[31:16] = 16'h0200;
        cap_valid = 1'b1;
        cap_data  = rd;
        tick();
        cap_valid = 1'b0;
`ifdef PE_DRAIN_RELU_EN
        chk("t6 relu", out_data, 64'h0000_0000_0200_0000);
`else
        chk("t6 raw", out_data, 64'h0000_0000_0200_FE00);
`endif
        for (int b = 0; b < 8; b++)
            tick();
        chk("t6 done valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
